// File: rtl/sha256_pkg.sv
// Shared constants, FSM state encoding and the padding rule for the SHA-256
// single-block feeder.
package sha256_pkg;

  localparam int BLOCK_BYTES    = 64;
  localparam int MAX_MSG_BYTES  = 55;
  localparam int LEN_HI_IDX     = 62;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam int DIGEST_NIBBLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_DROP      = 3'd2,
    ST_WAIT_CORE = 3'd3,
    ST_SEND      = 3'd4,
    ST_COLLECT   = 3'd5
  } feeder_state_e;

  // Byte idx of the padded block for a message of msg_len bytes (1..55).
  function automatic logic [7:0] pad_byte(input logic [5:0] idx,
                                          input logic [5:0] msg_len,
                                          input logic [7:0] msg_byte);
    logic [8:0] lenbits;
    lenbits = {msg_len, 3'b000};
    if (idx < msg_len) begin
      pad_byte = msg_byte;
    end else if (idx == msg_len) begin
      pad_byte = PAD_BYTE;
    end else if (idx == 6'(LEN_HI_IDX)) begin
      pad_byte = {7'b0000000, lenbits[8]};
    end else if (idx == 6'(LEN_HI_IDX + 1)) begin
      pad_byte = lenbits[7:0];
    end else begin
      pad_byte = 8'h00;
    end
  endfunction

endpackage

// File: rtl/sha256_digest_collector.sv
// Assembles the core's MSB-first digest nibbles into a 256-bit word and
// pulses done in the cycle after the last nibble.
module sha256_digest_collector
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         clear,
  input  logic         core_out_en,
  input  logic [3:0]   core_digest_nib,
  output logic [255:0] digest,
  output logic         done
);

  logic [255:0] shift_q;
  logic [6:0]   cnt_q;
  logic         done_q;

  // Shift register, nibble counter and completion pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      shift_q <= 256'd0;
      cnt_q   <= 7'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (core_out_en) begin
        shift_q <= {shift_q[251:0], core_digest_nib};
        if (cnt_q == 7'(DIGEST_NIBBLES - 1)) begin
          cnt_q  <= 7'd0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 7'd1;
        end
      end else begin
        cnt_q <= cnt_q;
      end
    end
  end

  assign digest = shift_q;
  assign done   = done_q;

endmodule

// File: rtl/sha256_block_feeder.sv
// Buffers a 1..55 byte message, streams it to the SHA-256 core as one padded
// block, then gathers the returned digest.
module sha256_block_feeder
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  input  logic         core_busy,
  input  logic         core_out_en,
  input  logic [3:0]   core_digest_nib,
  output logic         first_block,
  output logic         last_block,
  output logic [7:0]   blk_data,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         err
);

  feeder_state_e state_q;
  logic [5:0]    len_q;
  logic [5:0]    idx_q;
  logic [7:0]    buf_q [MAX_MSG_BYTES];
  logic          first_block_q;
  logic          last_block_q;
  logic [7:0]    blk_data_q;
  logic          err_q;

  logic          accept_s;
  logic          loading_s;
  logic [7:0]    msg_byte_s;
  logic          collect_en_s;
  logic          done_s;

  // Ready is held low during reset and whenever a message is being hashed.
  always_comb begin
    if (reset) begin
      in_ready = 1'b0;
    end else if (state_q == ST_IDLE || state_q == ST_LOAD || state_q == ST_DROP) begin
      in_ready = 1'b1;
    end else begin
      in_ready = 1'b0;
    end
  end

  assign accept_s  = in_valid && in_ready;
  assign loading_s = (state_q == ST_IDLE || state_q == ST_LOAD) && (len_q < 6'(MAX_MSG_BYTES));

  // Message buffer; beyond the stored length the contents are never read.
  always_ff @(posedge clk) begin
    if (accept_s && loading_s) begin
      buf_q[len_q] <= in_data;
    end
  end

  // Buffer lookup guarded so padding indices never address past the array.
  always_comb begin
    if (idx_q < 6'(MAX_MSG_BYTES)) begin
      msg_byte_s = buf_q[idx_q];
    end else begin
      msg_byte_s = 8'h00;
    end
  end

  // Main control FSM with registered strobes and block data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= 6'd0;
      idx_q         <= 6'd0;
      first_block_q <= 1'b0;
      last_block_q  <= 1'b0;
      blk_data_q    <= 8'h00;
      err_q         <= 1'b0;
    end else begin
      first_block_q <= 1'b0;
      last_block_q  <= 1'b0;
      blk_data_q    <= 8'h00;
      err_q         <= 1'b0;
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (accept_s) begin
            if (len_q == 6'(MAX_MSG_BYTES)) begin
              err_q   <= 1'b1;
              len_q   <= 6'd0;
              state_q <= in_last ? ST_IDLE : ST_DROP;
            end else if (in_last) begin
              len_q   <= len_q + 6'd1;
              state_q <= ST_WAIT_CORE;
            end else begin
              len_q   <= len_q + 6'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        ST_DROP: begin
          if (accept_s && in_last) begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT_CORE: begin
          if (!core_busy) begin
            first_block_q <= 1'b1;
            idx_q         <= 6'd0;
            state_q       <= ST_SEND;
          end
        end
        ST_SEND: begin
          blk_data_q   <= pad_byte(idx_q, len_q, msg_byte_s);
          last_block_q <= (idx_q == 6'd0);
          idx_q        <= idx_q + 6'd1;
          if (idx_q == 6'(BLOCK_BYTES - 1)) begin
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (done_s) begin
            len_q   <= 6'd0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Nibbles only count while collecting, and not in the completion cycle.
  assign collect_en_s = core_out_en && (state_q == ST_COLLECT) && !done_s;

  sha256_digest_collector u_collector (
    .clk             (clk),
    .clear           (reset),
    .core_out_en     (collect_en_s),
    .core_digest_nib (core_digest_nib),
    .digest          (digest),
    .done            (done_s)
  );

  assign first_block  = first_block_q;
  assign last_block   = last_block_q;
  assign blk_data     = blk_data_q;
  assign digest_valid = done_s;
  assign err          = err_q;

endmodule

// File: tb/tb_sha256_block_feeder.sv
// Self-checking bench: table of message lengths, directed corner cases and
// random messages checked against a queue-based padding model.
module tb_sha256_block_feeder;

  typedef logic [7:0] bq_t [$];

  typedef struct {
    int         len;
    logic [7:0] b62;
    logic [7:0] b63;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         core_busy;
  logic         core_out_en;
  logic [3:0]   core_digest_nib;
  logic         first_block;
  logic         last_block;
  logic [7:0]   blk_data;
  logic [255:0] digest;
  logic         digest_valid;
  logic         err;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  int fb_cnt = 0;
  int dv_cnt = 0;

  always #5 clk = ~clk;

  sha256_block_feeder dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .core_busy       (core_busy),
    .core_out_en     (core_out_en),
    .core_digest_nib (core_digest_nib),
    .first_block     (first_block),
    .last_block      (last_block),
    .blk_data        (blk_data),
    .digest          (digest),
    .digest_valid    (digest_valid),
    .err             (err)
  );

  always @(negedge clk) begin
    if (err) err_cnt <= err_cnt + 1;
    if (first_block) fb_cnt <= fb_cnt + 1;
    if (digest_valid) dv_cnt <= dv_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bq_t pad_model(input bq_t msg);
    bq_t b;
    int bits;
    b = msg;
    bits = msg.size() * 8;
    b.push_back(8'h80);
    while (b.size() < 62) b.push_back(8'h00);
    b.push_back(8'(bits >> 8));
    b.push_back(8'(bits & 255));
    return b;
  endfunction

  function automatic bq_t rand_msg(input int len);
    bq_t m;
    for (int k = 0; k < len; k++) m.push_back(8'($urandom));
    return m;
  endfunction

  task automatic send_msg(input bq_t msg, input bit noise);
    int n;
    for (int k = 0; k < msg.size(); k++) begin
      in_valid = 1'b1;
      in_data = msg[k];
      in_last = (k == msg.size() - 1);
      core_out_en = noise;
      core_digest_nib = 4'($urandom);
      n = 0;
      while (!in_ready && n < 400) begin
        step();
        n++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    core_out_en = 1'b0;
  endtask

  task automatic run_block(input bq_t msg, input logic [255:0] dig, input int busy_cycles,
                           input int abort_at, input bit noise, output bq_t got);
    bq_t exp;
    logic [255:0] prev;
    int n, fb0, dv0;
    got = {};
    prev = digest;
    exp = pad_model(msg);
    fb0 = fb_cnt;
    dv0 = dv_cnt;
    if (busy_cycles > 0) core_busy = 1'b1;
    send_msg(msg, noise);
    chk("in_ready_low_after_last", in_ready, 0);
    chk("digest_hold_load", digest, prev);
    if (busy_cycles > 0) begin
      for (int c = 0; c < busy_cycles; c++) begin
        step();
        chk("in_ready_low_busy", in_ready, 0);
        chk("no_first_block_busy", first_block, 0);
      end
      core_busy = 1'b0;
      step();
      chk("first_block_after_busy", first_block, 1);
    end else begin
      n = 0;
      while (!first_block && n < 100) begin
        step();
        n++;
      end
      chk("first_block_seen", first_block, 1);
    end
    chk("last_block_low_at_T", last_block, 0);
    for (int i = 0; i < 64; i++) begin
      step();
      got.push_back(blk_data);
      chk($sformatf("blk_byte_%0d", i), blk_data, exp[i]);
      chk($sformatf("last_block_%0d", i), last_block, (i == 0));
      if (i == abort_at) begin
        reset = 1'b1;
        step();
        chk("rst_first_block", first_block, 0);
        chk("rst_last_block", last_block, 0);
        chk("rst_blk_data", blk_data, 0);
        chk("rst_digest", digest, 0);
        chk("rst_digest_valid", digest_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
        reset = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        return;
      end
    end
    step();
    chk("blk_data_zero_after_send", blk_data, 0);
    repeat (68) step();
    chk("digest_hold_wait", digest, prev);
    chk("fb_once", fb_cnt, fb0 + 1);
    for (int k = 0; k < 64; k++) begin
      core_out_en = 1'b1;
      core_digest_nib = dig[255 - 4 * k -: 4];
      step();
      if (k < 63) chk("no_early_valid", digest_valid, 0);
    end
    core_out_en = 1'b0;
    chk("digest_valid", digest_valid, 1);
    chk("digest", digest, dig);
    step();
    chk("digest_valid_one_cycle", digest_valid, 0);
    chk("dv_once", dv_cnt, dv0 + 1);
    chk("in_ready_after_digest", in_ready, 1);
  endtask

  initial begin
    vec_t tbl [5];
    bq_t msg, got;
    logic [255:0] dig;
    int e0, f0, d0;

    tbl[0] = '{1, 8'h00, 8'h08};
    tbl[1] = '{3, 8'h00, 8'h18};
    tbl[2] = '{32, 8'h01, 8'h00};
    tbl[3] = '{54, 8'h01, 8'hB0};
    tbl[4] = '{55, 8'h01, 8'hB8};

    reset = 1'b1;
    in_data = 8'h00;
    in_valid = 1'b0;
    in_last = 1'b0;
    core_busy = 1'b0;
    core_out_en = 1'b0;
    core_digest_nib = 4'h0;
    repeat (3) step();
    chk("reset_first_block", first_block, 0);
    chk("reset_last_block", last_block, 0);
    chk("reset_blk_data", blk_data, 0);
    chk("reset_digest", digest, 0);
    chk("reset_digest_valid", digest_valid, 0);
    chk("reset_err", err, 0);
    chk("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    chk("in_ready_idle", in_ready, 1);
    step();

    // "abc" with the well-known digest
    msg = '{8'h61, 8'h62, 8'h63};
    run_block(msg, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0, -1, 0, got);

    // Length table: padding marker and length bytes
    foreach (tbl[t]) begin
      msg = rand_msg(tbl[t].len);
      dig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_block(msg, dig, 0, -1, 0, got);
      chk($sformatf("tbl%0d_pad80", t), got[tbl[t].len], 8'h80);
      chk($sformatf("tbl%0d_b62", t), got[62], tbl[t].b62);
      chk($sformatf("tbl%0d_b63", t), got[63], tbl[t].b63);
    end

    // 56-byte message with in_last on the 56th byte, then "a"
    e0 = err_cnt;
    f0 = fb_cnt;
    send_msg(rand_msg(56), 0);
    repeat (3) step();
    chk("err56_count", err_cnt, e0 + 1);
    chk("err56_no_first_block", fb_cnt, f0);
    chk("err56_in_ready", in_ready, 1);
    msg = '{8'h61};
    run_block(msg, {8{$urandom}}, 0, -1, 0, got);

    // 60-byte message goes through DROP
    e0 = err_cnt;
    f0 = fb_cnt;
    send_msg(rand_msg(60), 0);
    repeat (3) step();
    chk("err60_count", err_cnt, e0 + 1);
    chk("err60_no_first_block", fb_cnt, f0);
    chk("err60_in_ready", in_ready, 1);

    // Core busy for 20 cycles after in_last
    run_block(rand_msg(10), {8{$urandom}}, 20, -1, 0, got);

    // Reset at SEND byte 30, then a fresh "abc"
    e0 = err_cnt;
    run_block(rand_msg(20), {8{$urandom}}, 0, 30, 0, got);
    chk("no_err_on_abort", err_cnt, e0);
    msg = '{8'h61, 8'h62, 8'h63};
    run_block(msg, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, 0, -1, 0, got);

    // core_out_en noise in IDLE must not disturb the digest
    dig = digest;
    d0 = dv_cnt;
    core_out_en = 1'b1;
    for (int k = 0; k < 70; k++) begin
      core_digest_nib = 4'($urandom);
      step();
    end
    core_out_en = 1'b0;
    step();
    chk("idle_noise_digest", digest, dig);
    chk("idle_noise_no_valid", dv_cnt, d0);
    run_block(rand_msg(17), {8{$urandom}}, 0, -1, 1, got);

    // Random messages against the padding model
    for (int r = 0; r < 15; r++) begin
      msg = rand_msg($urandom_range(1, 55));
      dig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      run_block(msg, dig, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0, -1,
                1'($urandom_range(0, 1)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
